// File: rtl/dense_stream_mac_if.sv
// Control, result and weight-load bundle of dense_stream_mac.
// The master side drives requests and the slave (the layer) answers.
interface dense_stream_mac_if #(
  parameter int N_IN  = 64,
  parameter int N_OUT = 16,
  parameter int DW    = 16
);
  localparam int AW = $clog2(N_IN * N_OUT + N_OUT);

  logic                  ap_start;
  logic                  ap_ready;
  logic                  ap_idle;
  logic                  ap_done;
  logic [N_IN*DW-1:0]    in_data;
  logic [N_OUT*DW-1:0]   out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [N_OUT-1:0]      sat_flag;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DW-1:0]         wr_data;
  logic                  wr_err;

  modport master (
    output ap_start, in_data, out_ready, wr_en, wr_addr, wr_data,
    input  ap_ready, ap_idle, ap_done, out_data, out_valid, sat_flag, wr_err
  );

  modport slave (
    input  ap_start, in_data, out_ready, wr_en, wr_addr, wr_data,
    output ap_ready, ap_idle, ap_done, out_data, out_valid, sat_flag, wr_err
  );
endinterface

// File: rtl/dense_stream_mac.sv
// Runtime-programmable fully-connected layer: P columns per cycle through a
// multiply / adder-tree pipeline, full-precision accumulate, then round+saturate.
module dense_stream_mac #(
  parameter int N_IN  = 64,
  parameter int N_OUT = 16,
  parameter int DW    = 16,
  parameter int FRAC  = 10,
  parameter int P     = 8,
  parameter int RELU  = 1,
  parameter int ACC_W = 2 * DW + $clog2(N_IN) + 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  dense_stream_mac_if.slave bus
);
  localparam int NT  = N_IN / P;
  localparam int TW  = (NT > 1) ? $clog2(NT) : 1;
  localparam int NW  = N_IN * N_OUT;
  localparam int NWA = $clog2(NW);
  localparam int XA  = $clog2(N_IN);
  localparam int AW  = $clog2(NW + N_OUT);
  localparam int PW  = 2 * DW;
  localparam int SW  = PW + $clog2(P);
  localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1) <<< (FRAC - 1);
  localparam logic signed [ACC_W-1:0] VMAX = ACC_W'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] VMIN = -VMAX - ACC_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_FINAL, S_HOLD} state_t;

  state_t            r_state, w_state_next;
  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  logic [TW-1:0]     r_tile;
  logic              r_drain;
  logic              r_s1_valid, r_s2_valid;
  logic              r_out_valid;
  logic              r_wr_err;
  logic              w_in_idle, w_start;
  logic              w_addr_ok, w_is_bias, w_wr_commit, w_wr_bias;
  logic [AW-1:0]     w_bias_off;

  // Reset asserts asynchronously, releases on the clock.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_rst_sync <= 2'b00;
    else           r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_in_idle   = (r_state == S_IDLE);
  assign w_start     = w_in_idle && bus.ap_start;
  assign w_addr_ok   = {1'b0, bus.wr_addr} < (AW + 1)'(NW + N_OUT);
  assign w_is_bias   = bus.wr_addr >= AW'(NW);
  assign w_wr_commit = bus.wr_en && w_in_idle && w_addr_ok;
  assign w_wr_bias   = w_wr_commit && w_is_bias;
  assign w_bias_off  = bus.wr_addr - AW'(NW);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.ap_start) w_state_next = S_MAC;
      S_MAC:   if (r_tile == TW'(NT - 1)) w_state_next = S_DRAIN;
      S_DRAIN: if (r_drain) w_state_next = S_FINAL;
      S_FINAL: w_state_next = S_HOLD;
      S_HOLD:  if (bus.out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= S_IDLE;
      r_tile      <= '0;
      r_drain     <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_wr_err    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_s1_valid <= (r_state == S_MAC);
      r_s2_valid <= r_s1_valid;
      r_wr_err   <= bus.wr_en && !(w_in_idle && w_addr_ok);
      if (w_start)                r_tile <= '0;
      else if (r_state == S_MAC)  r_tile <= r_tile + TW'(1);
      r_drain <= (r_state == S_DRAIN) ? ~r_drain : 1'b0;
      if (r_state == S_FINAL)                        r_out_valid <= 1'b1;
      else if (r_state == S_HOLD && bus.out_ready)   r_out_valid <= 1'b0;
    end
  end

  // Weights live in registers: every tile reads P*N_OUT of them at once.
  logic [DW-1:0]        r_w [NW];
  logic signed [DW-1:0] r_x [N_IN];

  always_ff @(posedge ap_clk) begin
    if (w_wr_commit && !w_is_bias) r_w[bus.wr_addr[NWA-1:0]] <= bus.wr_data;
  end

  genvar gi, gp;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : gen_xcap
      always_ff @(posedge ap_clk) begin
        if (w_start) r_x[gi] <= $signed(bus.in_data[gi*DW +: DW]);
      end
    end

    for (gi = 0; gi < N_OUT; gi++) begin : gen_out
      logic signed [PW-1:0]    r_prod [P];
      logic signed [SW-1:0]    r_sum, w_sum;
      logic signed [ACC_W-1:0] r_acc, w_bias_ext, w_rnd, w_shr;
      logic        [DW-1:0]    r_bias, w_bias_eff, r_out, w_clip, w_res;
      logic                    r_sat, w_hi, w_lo, w_bias_hit;

      // A bias written in the start cycle is forwarded into that run.
      assign w_bias_hit = w_wr_bias && (w_bias_off == AW'(gi));
      assign w_bias_eff = w_bias_hit ? bus.wr_data : r_bias;
      assign w_bias_ext = ACC_W'($signed(w_bias_eff));

      always_ff @(posedge ap_clk) begin
        if (w_bias_hit) r_bias <= bus.wr_data;
      end

      for (gp = 0; gp < P; gp++) begin : gen_col
        logic signed [PW-1:0] w_wt, w_xv;
        assign w_wt = PW'($signed(r_w[NWA'((int'(r_tile) * P + gp) * N_OUT + gi)]));
        assign w_xv = PW'(r_x[XA'(int'(r_tile) * P + gp)]);
        always_ff @(posedge ap_clk) r_prod[gp] <= w_wt * w_xv;
      end

      always_comb begin
        w_sum = '0;
        for (int p = 0; p < P; p++) w_sum += SW'(r_prod[p]);
      end

      always_ff @(posedge ap_clk) r_sum <= w_sum;

      always_ff @(posedge ap_clk or negedge w_rst_n) begin
        if (!w_rst_n)        r_acc <= '0;
        else if (w_start)    r_acc <= w_bias_ext <<< FRAC;
        else if (r_s2_valid) r_acc <= r_acc + ACC_W'(r_sum);
      end

      assign w_rnd = r_acc + RND;
      assign w_shr = w_rnd >>> FRAC;
      assign w_hi  = w_shr > VMAX;
      assign w_lo  = w_shr < VMIN;

      always_comb begin
        w_clip = w_shr[DW-1:0];
        if (w_hi)      w_clip = {1'b0, {(DW - 1){1'b1}}};
        else if (w_lo) w_clip = {1'b1, {(DW - 1){1'b0}}};
        w_res = w_clip;
        if (RELU != 0 && w_clip[DW-1]) w_res = '0;
      end

      always_ff @(posedge ap_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
          r_out <= '0;
          r_sat <= 1'b0;
        end else if (r_state == S_FINAL) begin
          r_out <= w_res;
          r_sat <= w_hi | w_lo;
        end
      end

      assign bus.out_data[gi*DW +: DW] = r_out;
      assign bus.sat_flag[gi]          = r_sat;
    end
  endgenerate

  assign bus.ap_ready  = w_in_idle;
  assign bus.ap_idle   = w_in_idle && !bus.ap_start;
  assign bus.ap_done   = (r_state == S_HOLD) && bus.out_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.wr_err    = r_wr_err;
endmodule

// File: tb/tb_dense_stream_mac.sv
// Scoreboard bench for dense_stream_mac: a ReLU build and a pass-through build
// run side by side on the same stimulus against a wide-integer reference model.
module tb_dense_stream_mac;
  localparam int N_IN  = 64;
  localparam int N_OUT = 16;
  localparam int DW    = 16;
  localparam int FRAC  = 10;
  localparam int P     = 8;
  localparam int NW    = N_IN * N_OUT;
  localparam int AW    = $clog2(NW + N_OUT);
  localparam int LAT   = N_IN / P + 3;
  localparam int VW    = N_OUT * DW;

  typedef struct {
    logic [VW-1:0]    d1, d0;
    logic [N_OUT-1:0] s1, s0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dense_stream_mac_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) u_if ();
  dense_stream_mac_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) u_if0 ();

  assign u_if0.ap_start  = u_if.ap_start;
  assign u_if0.in_data   = u_if.in_data;
  assign u_if0.out_ready = u_if.out_ready;
  assign u_if0.wr_en     = u_if.wr_en;
  assign u_if0.wr_addr   = u_if.wr_addr;
  assign u_if0.wr_data   = u_if.wr_data;

  dense_stream_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC), .P(P), .RELU(1)) u_dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .bus(u_if.slave));
  dense_stream_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .FRAC(FRAC), .P(P), .RELU(0)) u_dut0 (
    .ap_clk(clk), .ap_rst_n(rst_n), .bus(u_if0.slave));

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] m_w [NW];
  logic [DW-1:0] m_b [N_OUT];
  exp_t          sb [$];

  task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [N_IN*DW-1:0] x, input bit relu,
                                output logic [VW-1:0] o, output logic [N_OUT-1:0] s);
    longint acc, v, vmax, vmin;
    vmax = (longint'(1) << (DW - 1)) - 1;
    vmin = -(longint'(1) << (DW - 1));
    o = '0;
    s = '0;
    for (int r = 0; r < N_OUT; r++) begin
      acc = longint'($signed(m_b[r])) * (longint'(1) << FRAC);
      for (int c = 0; c < N_IN; c++)
        acc += longint'($signed(m_w[c*N_OUT+r])) * longint'($signed(x[c*DW +: DW]));
      v = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
      if (v > vmax) begin v = vmax; s[r] = 1'b1; end
      else if (v < vmin) begin v = vmin; s[r] = 1'b1; end
      if (relu && v < 0) v = 0;
      o[r*DW +: DW] = v[DW-1:0];
    end
  endfunction

  function automatic logic [N_IN*DW-1:0] rand_vec();
    logic [N_IN*DW-1:0] v;
    for (int i = 0; i < N_IN * DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [N_IN*DW-1:0] fill_vec(input int kind);
    logic [N_IN*DW-1:0] v;
    for (int i = 0; i < N_IN; i++)
      v[i*DW +: DW] = (kind == 0) ? DW'(i * 16'h0200) : 16'h0400;
    return v;
  endfunction

  task automatic model_write(input int a, input logic [DW-1:0] d);
    if (a < NW) m_w[a] = d;
    else if (a < NW + N_OUT) m_b[a-NW] = d;
  endtask

  // kind: 0 identity, 1 zero, 2 zero W / bias -1.0, 3 W=+31, 4 W=-31, 5 small random
  task automatic load(input int kind);
    for (int a = 0; a < NW + N_OUT; a++) begin
      logic [DW-1:0] v;
      v = '0;
      if (a < NW) begin
        case (kind)
          0: v = ((a / N_OUT) == (a % N_OUT)) ? 16'h0400 : 16'h0000;
          3: v = 16'h7C00;
          4: v = 16'h8400;
          5: v = DW'($urandom_range(0, 511)) - 16'd256;
          default: v = '0;
        endcase
      end else begin
        if (kind == 2) v = 16'hFC00;
        else if (kind == 5) v = DW'($urandom_range(0, 4095)) - 16'd2048;
      end
      @(negedge clk);
      u_if.wr_en   = 1'b1;
      u_if.wr_addr = AW'(a);
      u_if.wr_data = v;
      model_write(a, v);
    end
    @(negedge clk);
    u_if.wr_en = 1'b0;
    check_eq("load_wr_err", u_if.wr_err, 0);
  endtask

  task automatic write1(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    u_if.wr_en   = 1'b1;
    u_if.wr_addr = AW'(a);
    u_if.wr_data = d;
    model_write(a, d);
    @(negedge clk);
    u_if.wr_en = 1'b0;
  endtask

  task automatic start_run(input logic [N_IN*DW-1:0] x, input bit do_wr, input int wa,
                           input logic [DW-1:0] wd);
    exp_t e;
    @(negedge clk);
    u_if.ap_start = 1'b1;
    u_if.in_data  = x;
    if (do_wr) begin
      u_if.wr_en   = 1'b1;
      u_if.wr_addr = AW'(wa);
      u_if.wr_data = wd;
      model_write(wa, wd);
    end
    model(x, 1'b1, e.d1, e.s1);
    model(x, 1'b0, e.d0, e.s0);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    u_if.ap_start = 1'b0;
    u_if.wr_en    = 1'b0;
    u_if.in_data  = rand_vec();
  endtask

  task automatic wait_valid();
    int lat;
    lat = 0;
    while (!u_if.out_valid && lat < 4 * LAT) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (lat == 3) check_eq("busy_ready", u_if.ap_ready, 0);
    end
    check_eq("latency", lat, LAT);
    check_eq("valid_relu0", u_if0.out_valid, 1);
  endtask

  task automatic finish_run(input int hold, input int bp_addr);
    logic [VW-1:0] snap;
    exp_t e;
    snap = u_if.out_data;
    for (int h = 0; h < hold; h++) begin
      check_eq("hold_data", u_if.out_data, snap);
      check_eq("hold_valid", u_if.out_valid, 1);
      if (h == 0) begin
        u_if.ap_start = 1'b1;
        u_if.wr_en    = 1'b1;
        u_if.wr_addr  = AW'(bp_addr);
        u_if.wr_data  = 16'h1234;
      end else if (h == 1) begin
        check_eq("hold_wr_err", u_if.wr_err, 1);
        u_if.ap_start = 1'b0;
        u_if.wr_en    = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    u_if.out_ready = 1'b1;
    #1;
    check_eq("done_pulse", u_if.ap_done, 1);
    check_eq("sb_nonempty", sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("out_relu1", u_if.out_data, e.d1);
      check_eq("sat_relu1", u_if.sat_flag, e.s1);
      check_eq("out_relu0", u_if0.out_data, e.d0);
      check_eq("sat_relu0", u_if0.sat_flag, e.s0);
    end
    @(posedge clk);
    @(negedge clk);
    u_if.out_ready = 1'b0;
    check_eq("done_low", u_if.ap_done, 0);
    check_eq("valid_low", u_if.out_valid, 0);
    check_eq("idle_ready", u_if.ap_ready, 1);
    @(posedge clk);
    @(negedge clk);
    check_eq("no_queued_start", u_if.ap_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N_IN*DW-1:0] x;
    u_if.ap_start  = 1'b0;
    u_if.in_data   = '0;
    u_if.out_ready = 1'b0;
    u_if.wr_en     = 1'b0;
    u_if.wr_addr   = '0;
    u_if.wr_data   = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", u_if.out_valid, 0);
    check_eq("rst_data", u_if.out_data, 0);
    check_eq("rst_sat", u_if.sat_flag, 0);
    check_eq("rst_done", u_if.ap_done, 0);
    check_eq("rst_wr_err", u_if.wr_err, 0);
    check_eq("rst_ready", u_if.ap_ready, 1);
    check_eq("rst_idle", u_if.ap_idle, 1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    write1(NW + N_OUT, 16'hBEEF);
    check_eq("oob_wr_err", u_if.wr_err, 1);
    @(negedge clk);
    check_eq("oob_wr_err_clr", u_if.wr_err, 0);

    // identity with back-pressure; rejected write targets W[1][1]
    load(0);
    start_run(fill_vec(0), 1'b0, 0, '0);
    wait_valid();
    finish_run(5, N_OUT + 1);

    // reset in the middle of MAC, then rerun identity on retained weights
    start_run(fill_vec(0), 1'b0, 0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", u_if.out_valid, 0);
    check_eq("midrst_data", u_if.out_data, 0);
    check_eq("midrst_data0", u_if0.out_data, 0);
    check_eq("midrst_ready", u_if.ap_ready, 1);
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("midrst_no_result", u_if.out_valid, 0);
    start_run(fill_vec(0), 1'b0, 0, '0);
    wait_valid();
    finish_run(0, 0);

    // rounding half-up on W[0][0]
    load(1);
    write1(0, 16'h0200);
    x = rand_vec();
    x[DW-1:0] = 16'h0001;
    start_run(x, 1'b0, 0, '0);
    wait_valid();
    finish_run(0, 0);
    write1(0, 16'h0100);
    start_run(x, 1'b0, 0, '0);
    wait_valid();
    finish_run(0, 0);

    // negative bias through ReLU, plus a bias write in the start cycle
    load(2);
    start_run(rand_vec(), 1'b1, NW + 3, 16'h0800);
    wait_valid();
    finish_run(0, 0);

    // positive and negative saturation
    load(3);
    start_run(fill_vec(1), 1'b0, 0, '0);
    wait_valid();
    finish_run(0, 0);
    load(4);
    start_run(fill_vec(1), 1'b0, 0, '0);
    wait_valid();
    finish_run(0, 0);

    // random weights and inputs
    load(5);
    for (int t = 0; t < 3; t++) begin
      start_run(rand_vec(), 1'b0, 0, '0);
      wait_valid();
      finish_run(0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dense_stream_mac.md
# dense_stream_mac

Parametrised, runtime-programmable fully-connected layer: computes out[r] = act(bias[r] + Σ_c W[c][r]·x[c]) for N_OUT outputs over N_IN signed fixed-point inputs. P columns are processed per cycle in a pipelined multiply/reduce tree with full-precision accumulation, then a single round-and-saturate step. Weights and biases are written through a load port rather than fixed at elaboration. The output uses a valid/ready handshake so the block can feed the next layer in a chained network.

## Interface
- N_IN, 64, input vector length; must be a multiple of P
- N_OUT, 16, output vector length
- DW, 16, data/weight/bias width (signed two's complement)
- FRAC, 10, fractional bits of all DW-wide quantities
- P, 8, columns processed per cycle; power of 2
- RELU, 1, 1 = clamp negative results to 0; 0 = pass through
- ACC_W, 2*DW+$clog2(N_IN)+1, accumulator width (derived)

- ap_clk  in  1  clock, rising edge
- ap_rst_n  in  1  reset, asynchronous, active-low
- ap_start  in  1  start request; sampled only in IDLE
- ap_ready  out  1  high in IDLE: start will be accepted
- ap_idle  out  1  high in IDLE and ap_start low
- ap_done  out  1  one-cycle pulse on output handshake (out_valid && out_ready)
- in_data  in  N_IN*DW  input vector; element i at bits [DW*i +: DW]; captured on start
- out_data  out  N_OUT*DW  result vector, same packing
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- sat_flag  out  N_OUT  per-output saturation occurred; valid with out_valid
- wr_en  in  1  weight/bias write strobe
- wr_addr  in  $clog2(N_IN*N_OUT+N_OUT)  a < N_IN*N_OUT: W at index c*N_OUT+r; a = N_IN*N_OUT+r: bias[r]
- wr_data  in  DW  value written
- wr_err  out  1  one-cycle pulse: write rejected

## Operation
- States: IDLE → MAC → DRAIN → FINAL → HOLD → IDLE.
- IDLE: ap_start high at an edge captures in_data into an internal register, clears tile counter, loads acc[r] = sign-extended bias[r] << FRAC, enters MAC.
- MAC: N_IN/P cycles; tile k multiplies columns k*P..k*P+P-1 against captured input. Products full 2*DW bits, never truncated. Stage 1 registers products; stage 2 registers the P-input adder tree per output; accumulator adds stage-2 sum when its valid tag is set. After last tile → DRAIN.
- DRAIN: 2 cycles while the pipeline empties.
- FINAL: per output, add 1<<(FRAC-1) (round half up), arithmetic shift right FRAC, saturate to [-2^(DW-1), 2^(DW-1)-1], set sat_flag[r] if clamped, apply ReLU if RELU=1; register into out_data. → HOLD.
- HOLD: out_valid=1, out_data/sat_flag stable until out_ready; on handshake ap_done pulses, → IDLE.
- ap_start outside IDLE ignored (not queued).
- Weight writes commit only in IDLE. wr_en outside IDLE or wr_addr ≥ N_IN*N_OUT+N_OUT: ignored, wr_err pulses next cycle.
- wr_en and ap_start in same IDLE cycle: write commits at that edge and is used by that run.
- Reset: async clear of state (IDLE), counters, accumulators, out_data=0, out_valid=0, sat_flag=0, ap_done=0, wr_err=0. Weight/bias storage is NOT reset (retains values; undefined at power-up).

## Timing
- Start accepted at edge E0; out_valid rises after edge E0+N_IN/P+3 (defaults: 11 cycles).
- Handshake in first HOLD cycle → IDLE next cycle; new start accepted that cycle. Minimum period N_IN/P+5 cycles.
- in_data may change any time after E0.
- ap_rst_n low mid-operation: outputs go to reset values immediately (asynchronously); no partial result ever presented; release synchronised internally, IDLE on first edge after release.
- ap_ready = (state==IDLE); ap_idle = ap_ready && !ap_start.

## Test plan
- Identity: W[c][r]=0x0400 for c==r else 0, biases 0, x[i]=i*0x0200 → out[r]=r*0x0200, sat_flag=0, out_valid exactly 11 cycles after start.
- Rounding: W[0][0]=0x0200, x[0]=0x0001, all else 0 → out[0]=0x0001 (half-up); W[0][0]=0x0100 → out[0]=0x0000.
- Bias/ReLU: all W=0, bias[r]=0xFC00 → RELU=1: out=0x0000; RELU=0 build: out=0xFC00, sat_flag=0.
- Saturation: all W=0x7C00, all x=0x0400 → every out=0x7FFF, sat_flag all 1; W=0x8400 with RELU=0 → 0x8000, flags set.
- Back-pressure: out_ready low 5 cycles after out_valid → out_data stable, ap_start and wr_en ignored (wr_err pulses); raise out_ready → ap_done one cycle, IDLE next, weights unchanged.
- Reset mid-MAC: deassert ap_rst_n at cycle 4 of run → out_valid/out_data 0 at once; after release, rerun identity test without rewriting weights → identical result.
